// File: rtl/aes_host_sequencer.sv
// Host-side sequencer for the byte-serial AES-128 core: serialises key/plaintext onto
// din/cmd, issues start, gathers 16 ciphertext bytes and hands them out on valid/ready.
module aes_host_sequencer #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_key,
  input  logic [127:0] s_plain,
  input  logic         s_keep,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_cipher,
  output logic         err,
  output logic [7:0]   din,
  output logic [1:0]   cmd,
  input  logic [7:0]   dout,
  input  logic         ok,
  input  logic         ready
);

  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);
  localparam logic [1:0]  CMD_NOP  = 2'b00;
  localparam logic [1:0]  CMD_KEY  = 2'b01;
  localparam logic [1:0]  CMD_PT   = 2'b10;
  localparam logic [1:0]  CMD_GO   = 2'b11;

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, LOAD_KEY, LOAD_PT, START, WAIT_OK, COLLECT, HOLD
  } state_t;

  state_t       state, state_nxt;
  logic [3:0]   bc, bc_nxt;
  logic [15:0]  wd, wd_nxt, wd_inc;
  logic [127:0] key_q, plain_q;
  logic         skip_key, key_cached;
  logic         accept, capture, expire, key_done;
  logic [3:0]   byte_idx;
  logic [1:0]   cmd_nxt;
  logic [7:0]   din_nxt;

  // Next state, byte counter and watchdog
  always_comb begin
    state_nxt = state;
    bc_nxt    = bc;
    wd_inc    = wd + 16'd1;
    wd_nxt    = wd;
    accept    = s_valid & s_ready;
    capture   = 1'b0;
    expire    = 1'b0;
    key_done  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = WAIT_RDY;
          bc_nxt    = 4'd0;
        end
      end
      WAIT_RDY: begin
        if (ready) begin
          state_nxt = skip_key ? LOAD_PT : LOAD_KEY;
          bc_nxt    = 4'd0;
        end else if (wd_inc == WD_LIMIT) begin
          expire = 1'b1;
        end else begin
          wd_nxt = wd_inc;
        end
      end
      LOAD_KEY: begin
        bc_nxt = bc + 4'd1;
        if (bc == 4'd15) begin
          state_nxt = LOAD_PT;
          key_done  = 1'b1;
        end
      end
      LOAD_PT: begin
        bc_nxt = bc + 4'd1;
        if (bc == 4'd15) state_nxt = START;
      end
      START: begin
        state_nxt = WAIT_OK;
        bc_nxt    = 4'd0;
      end
      WAIT_OK, COLLECT: begin
        // A capture always beats a simultaneous watchdog expiry
        if (ok) begin
          capture = 1'b1;
          wd_nxt  = 16'd0;
          bc_nxt  = bc + 4'd1;
          state_nxt = (bc == 4'd15) ? HOLD : COLLECT;
        end else if (wd_inc == WD_LIMIT) begin
          expire = 1'b1;
        end else begin
          wd_nxt = wd_inc;
        end
      end
      HOLD: begin
        if (m_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (expire) begin
      state_nxt = IDLE;
      bc_nxt    = 4'd0;
    end
    if (state_nxt != state) wd_nxt = 16'd0;
  end

  // Bus byte for the cycle being entered, so cmd/din line up with the state register
  always_comb begin
    cmd_nxt  = CMD_NOP;
    din_nxt  = 8'd0;
    byte_idx = 4'd15 - bc_nxt;
    case (state_nxt)
      LOAD_KEY: begin
        cmd_nxt = CMD_KEY;
        din_nxt = key_q[{byte_idx, 3'b000} +: 8];
      end
      LOAD_PT: begin
        cmd_nxt = CMD_PT;
        din_nxt = plain_q[{byte_idx, 3'b000} +: 8];
      end
      START:   cmd_nxt = CMD_GO;
      default: cmd_nxt = CMD_NOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state      <= IDLE;
      bc         <= 4'd0;
      wd         <= 16'd0;
      key_q      <= 128'd0;
      plain_q    <= 128'd0;
      skip_key   <= 1'b0;
      key_cached <= 1'b0;
      m_cipher   <= 128'd0;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      err        <= 1'b0;
      cmd        <= CMD_NOP;
      din        <= 8'd0;
    end else begin
      state   <= state_nxt;
      bc      <= bc_nxt;
      wd      <= wd_nxt;
      s_ready <= (state_nxt == IDLE);
      m_valid <= (state_nxt == HOLD);
      err     <= expire;
      cmd     <= cmd_nxt;
      din     <= din_nxt;
      if (accept) begin
        plain_q  <= s_plain;
        skip_key <= s_keep & key_cached;
        if (!(s_keep & key_cached)) key_q <= s_key;
      end
      if (key_done)     key_cached <= 1'b1;
      else if (expire)  key_cached <= 1'b0;
      if (capture)      m_cipher <= {m_cipher[119:0], dout};
      else if (expire)  m_cipher <= 128'd0;
    end
  end

endmodule

// File: tb/tb_aes_host_sequencer.sv
// Directed/randomised bench for aes_host_sequencer with a behavioural byte-serial core stub.
module tb_aes_host_sequencer;

  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk, rst_, s_valid, s_ready, s_keep, m_valid, m_ready, err, ok, ready;
  logic [127:0] s_key, s_plain, m_cipher;
  logic [7:0]   din, dout;
  logic [1:0]   cmd;

  int n_chk = 0;
  int n_fail = 0;

  logic         stray_on, core_mute;
  logic         m_cached;
  logic [127:0] m_key, last_c;
  logic [7:0]   key_log[$];
  logic [7:0]   pt_log[$];
  logic [1:0]   cmd_log[$];

  aes_host_sequencer #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_(rst_), .s_valid(s_valid), .s_ready(s_ready), .s_key(s_key),
    .s_plain(s_plain), .s_keep(s_keep), .m_valid(m_valid), .m_ready(m_ready),
    .m_cipher(m_cipher), .err(err), .din(din), .cmd(cmd), .dout(dout), .ok(ok),
    .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the AES core: FIPS-197 vector is exact, anything else is a fixed mixing
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_K && p == FIPS_P) return FIPS_C;
    return k ^ {p[63:0], p[127:64]} ^ 128'h3c5a96e10f87d2b44b1ea5697c33e00f;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus monitor: records every non-nop command and its byte
  always @(negedge clk) begin
    if (cmd == 2'b01) key_log.push_back(din);
    if (cmd == 2'b10) pt_log.push_back(din);
    if (cmd != 2'b00) cmd_log.push_back(cmd);
  end

  // Core responder: absorbs key/plain bytes, answers start with 16 gapped bytes
  initial begin : core_stub
    logic [127:0] ck, cp, c;
    int gap;
    ok = 1'b0; dout = 8'd0; ck = '0; cp = '0;
    forever begin
      @(negedge clk);
      ok = stray_on;
      dout = 8'($urandom);
      if (cmd == 2'b01) ck = {ck[119:0], din};
      if (cmd == 2'b10) cp = {cp[119:0], din};
      if (cmd == 2'b11 && !core_mute) begin
        c = core_fn(ck, cp);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
          gap = (i == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 3));
          repeat (gap) begin
            @(negedge clk);
            ok = 1'b0;
            dout = 8'($urandom);
          end
          @(negedge clk);
          ok = 1'b1;
          dout = c[127 - 8*i -: 8];
        end
        @(negedge clk);
        ok = 1'b0;
      end
    end
  end

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: bench did not reach its end");
    $fatal(1, "bench stopped by guard");
  end

  task automatic wait_idle();
    int n = 0;
    while (s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("s_ready_idle", 128'(s_ready), 128'd1);
  endtask

  // One full transaction with ready-wait, download, collection and result backpressure
  task automatic run_txn(input logic [127:0] k, input logic [127:0] p, input logic keep,
                         input int rdy_d, input int bp);
    int kb, pb, cb, n, nk, bad;
    logic exp_kl;
    logic [127:0] exp_c, got;
    logic [1:0] want;
    exp_kl = !(keep && m_cached);
    if (exp_kl) m_key = k;
    exp_c = core_fn(m_key, p);
    nk = exp_kl ? 16 : 0;
    kb = key_log.size(); pb = pt_log.size(); cb = cmd_log.size();
    wait_idle();
    s_valid = 1'b1; s_key = k; s_plain = p; s_keep = keep; ready = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    for (int i = 0; i < rdy_d; i++) begin
      check("wait_rdy_cmd", 128'(cmd), 128'd0);
      if (i == rdy_d - 1) ready = 1'b1;
      @(negedge clk);
    end
    check("first_load_cmd", 128'(cmd), exp_kl ? 128'd1 : 128'd2);
    n = 0;
    while (m_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("m_valid_rise", 128'(m_valid), 128'd1);
    if (exp_kl) m_cached = 1'b1;
    check("cipher", m_cipher, exp_c);
    check("n_key_bytes", 128'(key_log.size() - kb), 128'(nk));
    check("n_pt_bytes", 128'(pt_log.size() - pb), 128'd16);
    got = '0;
    for (int i = 0; i < 16; i++) if (kb + i < key_log.size()) got = {got[119:0], key_log[kb + i]};
    if (exp_kl) check("key_bytes", got, k);
    got = '0;
    for (int i = 0; i < 16; i++) if (pb + i < pt_log.size()) got = {got[119:0], pt_log[pb + i]};
    check("pt_bytes", got, p);
    check("n_cmds", 128'(cmd_log.size() - cb), 128'(nk + 17));
    bad = 0;
    for (int i = 0; i < nk + 17 && cb + i < cmd_log.size(); i++) begin
      want = (i < nk) ? 2'b01 : ((i < nk + 16) ? 2'b10 : 2'b11);
      if (cmd_log[cb + i] !== want) bad++;
    end
    check("cmd_order", 128'(bad), 128'd0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_m_valid", 128'(m_valid), 128'd1);
      check("bp_cipher", m_cipher, exp_c);
      check("bp_s_ready", 128'(s_ready), 128'd0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("done_m_valid", 128'(m_valid), 128'd0);
    check("done_s_ready", 128'(s_ready), 128'd1);
    last_c = exp_c;
  endtask

  initial begin : main
    logic [127:0] k_wd;
    int n, cnt;
    rst_ = 1'b1; s_valid = 1'b0; s_key = '0; s_plain = '0; s_keep = 1'b0;
    m_ready = 1'b0; ready = 1'b1; stray_on = 1'b0; core_mute = 1'b0;
    m_cached = 1'b0; m_key = '0; last_c = '0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 128'(s_ready), 128'd0);
    check("rst_m_valid", 128'(m_valid), 128'd0);
    check("rst_err", 128'(err), 128'd0);
    check("rst_cmd", 128'(cmd), 128'd0);
    check("rst_din", 128'(din), 128'd0);
    check("rst_cipher", m_cipher, 128'd0);
    rst_ = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", 128'(s_ready), 128'd1);

    // s_keep right after reset still downloads the key
    run_txn(rnd128(), rnd128(), 1'b1, 2, 0);
    run_txn(FIPS_K, FIPS_P, 1'b0, 1, 0);
    check("fips_vector", m_cipher, FIPS_C);
    // Key reuse under the FIPS key
    run_txn(rnd128(), 128'd0, 1'b1, 3, 0);
    run_txn(rnd128(), rnd128(), 1'b1, 1, 20);
    for (int t = 0; t < 6; t++)
      run_txn(rnd128(), rnd128(), 1'($urandom_range(0, 1)),
              int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));

    // Stray ok while idle must not be captured
    stray_on = 1'b1;
    repeat (6) @(negedge clk);
    stray_on = 1'b0;
    @(negedge clk);
    check("stray_m_valid", 128'(m_valid), 128'd0);
    check("stray_cipher", m_cipher, last_c);
    check("stray_s_ready", 128'(s_ready), 128'd1);

    // Watchdog: core never answers start
    core_mute = 1'b1;
    k_wd = rnd128();
    wait_idle();
    s_valid = 1'b1; s_key = k_wd; s_plain = rnd128(); s_keep = 1'b0; ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    n = 0;
    while (cmd !== 2'b11 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wd_start_seen", 128'(cmd), 128'd3);
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (err === 1'b1) cnt++;
    end
    check("wd_no_early_err", 128'(cnt), 128'd0);
    @(negedge clk);
    check("wd_err_pulse", 128'(err), 128'd1);
    check("wd_no_m_valid", 128'(m_valid), 128'd0);
    @(negedge clk);
    check("wd_err_single", 128'(err), 128'd0);
    check("wd_s_ready", 128'(s_ready), 128'd1);
    m_cached = 1'b0;
    m_key = k_wd;
    core_mute = 1'b0;
    run_txn(k_wd, rnd128(), 1'b1, 1, 0);

    // Reset while LOAD_PT is on its eighth byte
    wait_idle();
    s_valid = 1'b1; s_key = rnd128(); s_plain = rnd128(); s_keep = 1'b0; ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    cnt = 0; n = 0;
    while (cnt < 8 && n < 100) begin
      @(negedge clk);
      n++;
      if (cmd === 2'b10) cnt++;
    end
    check("pt_bc7_reached", 128'(cnt), 128'd8);
    rst_ = 1'b1;
    @(negedge clk);
    check("mid_rst_cmd", 128'(cmd), 128'd0);
    check("mid_rst_din", 128'(din), 128'd0);
    check("mid_rst_err", 128'(err), 128'd0);
    check("mid_rst_s_ready", 128'(s_ready), 128'd0);
    rst_ = 1'b0;
    @(negedge clk);
    check("mid_rst_release", 128'(s_ready), 128'd1);
    check("mid_rst_no_err", 128'(err), 128'd0);
    m_cached = 1'b0;
    run_txn(rnd128(), rnd128(), 1'b1, 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
